// File: rtl/change_dispenser.sv
// change_dispenser
// Pays out a change amount one coin at a time to the coin hopper. Coins are
// chosen greedily (quarter, dime, nickel) against the on-board stock of each
// type. When the request is finished, the block reports completion, any
// shortfall and the unpaid remainder.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The sender holds valid and its payload (req_amt / coin) stable
// until that edge. The receiver may drive ready high or low at any time.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  change request handshake (ready only in IDLE)
//   req_amt          change amount in cents
//   coin_valid/ready coin offer to the hopper
//   coin             one-hot {dollar, half, quarter, dime, nickel}
//   done             one-cycle pulse when a request finishes
//   short            with done: request not fully paid
//   err              one-cycle pulse when a request is rejected
//   remaining        unpaid cents of the last finished request
//   refill_valid     add one coin of type refill_coin to stock
//   qty_q/d/n        current stock per coin type
//   dbg_state        FSM state (0 IDLE, 1 SELECT, 2 ISSUE, 3 FINISH)
module change_dispenser #(
  parameter int AMT_W      = 8,
  parameter int CNT_W      = 6,
  parameter int MAX_CHANGE = 95,
  parameter int INIT_Q     = 20,
  parameter int INIT_D     = 20,
  parameter int INIT_N     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             coin_valid,
  output logic [4:0]       coin,
  input  logic             coin_ready,
  output logic             done,
  output logic             short,
  output logic             err,
  output logic [AMT_W-1:0] remaining,
  input  logic             refill_valid,
  input  logic [4:0]       refill_coin,
  output logic [CNT_W-1:0] qty_q,
  output logic [CNT_W-1:0] qty_d,
  output logic [CNT_W-1:0] qty_n,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [AMT_W-1:0] VAL_Q   = AMT_W'(25);
  localparam logic [AMT_W-1:0] VAL_D   = AMT_W'(10);
  localparam logic [AMT_W-1:0] VAL_N   = AMT_W'(5);
  localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_CHANGE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [4:0] COIN_Q = 5'b00100;
  localparam logic [4:0] COIN_D = 5'b00010;
  localparam logic [4:0] COIN_N = 5'b00001;

  state_t           state;
  logic [AMT_W-1:0] rem;

  logic             req_bad;
  logic             can_q, can_d, can_n;
  logic             handshake;
  logic [AMT_W-1:0] coin_val;
  logic             inc_q, inc_d, inc_n;
  logic             dec_q, dec_d, dec_n;

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Selection uses registered rem and stock, so a refill during SELECT
  // only affects selection from the next cycle onwards.
  always_comb begin
    req_bad   = (req_amt > MAX_AMT) || ((req_amt % AMT_W'(5)) != '0);
    can_q     = (rem >= VAL_Q) && (qty_q != '0);
    can_d     = (rem >= VAL_D) && (qty_d != '0);
    can_n     = (rem >= VAL_N) && (qty_n != '0);
    handshake = (state == S_ISSUE) && coin_valid && coin_ready;
    coin_val  = coin[2] ? VAL_Q : (coin[1] ? VAL_D : VAL_N);
    inc_q     = refill_valid && (refill_coin == COIN_Q);
    inc_d     = refill_valid && (refill_coin == COIN_D);
    inc_n     = refill_valid && (refill_coin == COIN_N);
    dec_q     = handshake && coin[2];
    dec_d     = handshake && coin[1];
    dec_n     = handshake && coin[0];
  end

  // A type is decremented only after it was selected with nonzero stock, and
  // stock only drops through that path, so the decrement cannot wrap.
  function automatic logic [CNT_W-1:0] next_qty(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic dec);
    if (inc && !dec)
      next_qty = (cur == CNT_MAX) ? cur : cur + CNT_W'(1);
    else if (dec && !inc)
      next_qty = cur - CNT_W'(1);
    else
      next_qty = cur;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qty_q <= CNT_W'(INIT_Q);
      qty_d <= CNT_W'(INIT_D);
      qty_n <= CNT_W'(INIT_N);
    end else begin
      qty_q <= next_qty(qty_q, inc_q, dec_q);
      qty_d <= next_qty(qty_d, inc_d, dec_d);
      qty_n <= next_qty(qty_n, inc_n, dec_n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rem        <= '0;
      coin_valid <= 1'b0;
      coin       <= '0;
      done       <= 1'b0;
      short      <= 1'b0;
      err        <= 1'b0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              rem   <= req_amt;
              state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (can_q || can_d || can_n) begin
            coin       <= can_q ? COIN_Q : (can_d ? COIN_D : COIN_N);
            coin_valid <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            // Either fully paid (rem==0) or no usable coin left.
            done      <= 1'b1;
            short     <= (rem != '0);
            remaining <= rem;
            state     <= S_FINISH;
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            rem        <= rem - coin_val;
            coin_valid <= 1'b0;
            coin       <= '0;
            state      <= S_SELECT;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int AMT_W = 8;
  localparam int CNT_W = 6;
  localparam logic [4:0] CQ = 5'b00100;
  localparam logic [4:0] CD = 5'b00010;
  localparam logic [4:0] CN = 5'b00001;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic [AMT_W-1:0] req_amt;
  logic             req_ready;
  logic             coin_valid;
  logic [4:0]       coin;
  logic             coin_ready;
  logic             done;
  logic             short;
  logic             err;
  logic [AMT_W-1:0] remaining;
  logic             refill_valid;
  logic [4:0]       refill_coin;
  logic [CNT_W-1:0] qty_q, qty_d, qty_n;
  logic [1:0]       dbg_state;

  change_dispenser dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .coin_valid(coin_valid), .coin(coin), .coin_ready(coin_ready),
    .done(done), .short(short), .err(err), .remaining(remaining),
    .refill_valid(refill_valid), .refill_coin(refill_coin),
    .qty_q(qty_q), .qty_d(qty_d), .qty_n(qty_n), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [4:0] exp_q[$];          // expected coins in order
  logic [8:0] exp_done_q[$];     // {short, remaining}
  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (coin_valid && coin_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_coin", {27'd0, coin}, 32'd0);
        end else begin
          check("coin", {27'd0, coin}, {27'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          check("done_short_rem", {23'd0, short, remaining}, {23'd0, exp_done_q.pop_front()});
        end
      end
      if (err) err_seen++;
    end
  end

  // driver tasks (all return at posedge + 1)
  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_req(input logic [AMT_W-1:0] amt);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_amt   = amt;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < 500) begin
      @(posedge clk); n++;
    end
    if (n >= 500) check("drain_timeout", exp_q.size() + exp_done_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic refill(input logic [4:0] c);
    refill_valid = 1'b1;
    refill_coin  = c;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    refill_coin  = '0;
  endtask

  initial begin
    req_valid = 0; req_amt = 0; coin_ready = 1; refill_valid = 0; refill_coin = 0; rst = 0;
    #2;
    do_reset();

    // reset state
    check("rst_coin_valid", coin_valid, 0);
    check("rst_done", done, 0);
    check("rst_remaining", remaining, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_state", dbg_state, 0);
    check("rst_qty_q", qty_q, 20);
    check("rst_qty_d", qty_d, 20);
    check("rst_qty_n", qty_n, 20);

    // 40 cents with full stock: quarter, dime, nickel
    exp_q.push_back(CQ); exp_q.push_back(CD); exp_q.push_back(CN);
    exp_done_q.push_back({1'b0, 8'd0});
    send_req(8'd40);
    @(negedge clk);
    check("lat_sel_coin_valid", coin_valid, 0);
    @(negedge clk);
    check("lat_first_coin_valid", coin_valid, 1);
    wait_empty();
    check("t1_qty_q", qty_q, 19);
    check("t1_qty_d", qty_d, 19);
    check("t1_qty_n", qty_n, 19);

    // zero amount: done during T+2, no coins
    exp_done_q.push_back({1'b0, 8'd0});
    send_req(8'd0);
    @(negedge clk);
    check("zero_done_t1", done, 0);
    check("zero_coin_valid", coin_valid, 0);
    @(negedge clk);
    check("zero_done_t2", done, 1);
    wait_empty();

    // no quarters: 30 -> three dimes
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(CQ);
      exp_done_q.push_back({1'b0, 8'd0});
      send_req(8'd25);
      wait_empty();
    end
    check("drained_qty_q", qty_q, 0);
    exp_q.push_back(CD); exp_q.push_back(CD); exp_q.push_back(CD);
    exp_done_q.push_back({1'b0, 8'd0});
    send_req(8'd30);
    wait_empty();
    check("t3_qty_d", qty_d, 17);

    // Q=0, D=1, N=0; 15 -> one dime, short with 5 left
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(CN);
      exp_done_q.push_back({1'b0, 8'd0});
      send_req(8'd5);
      wait_empty();
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(CD);
      exp_done_q.push_back({1'b0, 8'd0});
      send_req(8'd10);
      wait_empty();
    end
    check("t4_pre_qty_d", qty_d, 1);
    check("t4_pre_qty_n", qty_n, 0);
    exp_q.push_back(CD);
    exp_done_q.push_back({1'b1, 8'd5});
    send_req(8'd15);
    wait_empty();
    check("t4_qty_d", qty_d, 0);
    check("t4_short_held", short, 1);
    check("t4_remaining_held", remaining, 5);

    // rejects: 37 (not multiple of 5) and 100 (> max)
    err_exp += 2;
    send_req(8'd37);
    @(negedge clk);
    check("err_37", err, 1);
    @(posedge clk); #1;
    send_req(8'd100);
    @(negedge clk);
    check("err_100", err, 1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk); #1;
    check("err_remaining_unchanged", remaining, 5);
    check("err_qty_q", qty_q, 0);
    check("err_qty_n", qty_n, 0);

    // stall in ISSUE, ignored request, refill during quarter handshake
    do_reset();
    coin_ready = 1'b0;
    exp_q.push_back(CQ);
    exp_done_q.push_back({1'b0, 8'd0});
    send_req(8'd25);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_amt   = 8'd10;
      @(negedge clk);
      check("stall_coin_valid", coin_valid, 1);
      check("stall_coin", coin, CQ);
      check("stall_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid    = 1'b0;
    coin_ready   = 1'b1;
    refill_valid = 1'b1;
    refill_coin  = CQ;
    @(posedge clk); #1;
    refill_valid = 1'b0;
    refill_coin  = '0;
    check("refill_issue_qty_q", qty_q, 20);
    wait_empty();
    repeat (3) @(posedge clk); #1;

    // refill in idle: increment, ignore non-one-hot and dollar, saturate
    refill(CN);
    check("refill_qty_n", qty_n, 21);
    refill(5'b00011);
    refill(5'b10000);
    check("refill_bad_qty_n", qty_n, 21);
    check("refill_bad_qty_d", qty_d, 20);
    check("refill_bad_qty_q", qty_q, 20);
    for (int i = 0; i < 50; i++) refill(CD);
    check("refill_sat_qty_d", qty_d, 63);

    // reset while in ISSUE
    coin_ready = 1'b0;
    exp_q.push_back(CD);
    exp_done_q.push_back({1'b0, 8'd0});
    send_req(8'd10);
    @(negedge clk); @(negedge clk);
    check("pre_rst_coin_valid", coin_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_coin_valid", coin_valid, 0);
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    check("post_rst_qty_q", qty_q, 20);
    check("post_rst_qty_d", qty_d, 20);
    check("post_rst_qty_n", qty_n, 20);
    repeat (4) @(posedge clk); #1;
    coin_ready = 1'b1;
    exp_q.push_back(CQ); exp_q.push_back(CD); exp_q.push_back(CN);
    exp_done_q.push_back({1'b0, 8'd0});
    send_req(8'd40);
    wait_empty();
    check("final_qty_d", qty_d, 19);

    // final report
    check("err_count", err_seen, err_exp);
    check("coin_q_empty", exp_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
